// File: rtl/trg_pkg.sv
// trg_pkg: shared lane count, statistics width, FSM state type and popcount for the trigger sequencer
package trg_pkg;

    localparam int N_SCROD = 12;
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        DEAD     = 2'd3
    } state_t;

    function automatic logic [3:0] popcount(input logic [N_SCROD-1:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < N_SCROD; i++) s = s + 4'(v[i]);
        return s;
    endfunction

endpackage

// File: rtl/trg_sequencer_if.sv
// trg_sequencer_if: trigger request, fan-out, acknowledge and status bundle of the trigger sequencer
interface trg_sequencer_if;
    import trg_pkg::*;

    logic                  TRG_SOFT;
    logic                  TRG_EXT;
    logic [N_SCROD-1:0]    TRG_MASK;
    logic [3:0]            MIN_SCRODS_REQUIRED;
    logic [N_SCROD-1:0]    ACK;
    logic [N_SCROD-1:0]    TRG;
    logic                  BUSY;
    logic                  TRG_DONE;
    logic                  TRG_TIMEOUT;
    logic [N_SCROD-1:0]    ACK_LATCHED;
    logic [2*STAT_W-1:0]   TRG_STATISTICS;

    modport master (
        output TRG_SOFT, TRG_EXT, TRG_MASK, MIN_SCRODS_REQUIRED, ACK,
        input  TRG, BUSY, TRG_DONE, TRG_TIMEOUT, ACK_LATCHED, TRG_STATISTICS
    );

    modport slave (
        input  TRG_SOFT, TRG_EXT, TRG_MASK, MIN_SCRODS_REQUIRED, ACK,
        output TRG, BUSY, TRG_DONE, TRG_TIMEOUT, ACK_LATCHED, TRG_STATISTICS
    );

endinterface

// File: rtl/trg_sync2.sv
// trg_sync2: two-flop synchroniser of configurable width with asynchronous active-low reset
module trg_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    // two-stage capture of an asynchronous input into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/trg_sequencer.sv
// trg_sequencer: 12-lane trigger fan-out with ACK quorum, timeout, deadtime and statistics; TRG_SEQ_PENDING_EN adds a one-deep pending request
module trg_sequencer
    import trg_pkg::*;
#(
    parameter int TRG_WIDTH   = 4,
    parameter int ACK_TIMEOUT = 1024,
    parameter int DEADTIME    = 16
) (
    input logic            CLK_80MHZ,
    input logic            RESET_N,
    trg_sequencer_if.slave bus
);

    localparam logic [15:0]       ISSUE_LAST   = 16'(TRG_WIDTH - 1);
    localparam logic [15:0]       TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0]       DEAD_LAST    = 16'((DEADTIME == 0) ? 0 : DEADTIME - 1);
    localparam logic [STAT_W-1:0] STAT_ONE     = STAT_W'(1);

    state_t              state, state_n;
    logic [15:0]         timer, timer_n;
    logic [N_SCROD-1:0]  ack_sync, mask_l, ack_latched;
    logic [3:0]          req_eff, mask_pop, req_now;
    logic                ext_sync, ext_prev, ext_edge, req, go;
    logic                start, done, tmo, done_q, tmo_q;
    logic [STAT_W-1:0]   n_issued, n_timeout;

    trg_sync2 #(.W(N_SCROD)) u_ack_sync (
        .clk   (CLK_80MHZ),
        .rst_n (RESET_N),
        .d     (bus.ACK),
        .q     (ack_sync)
    );

    trg_sync2 #(.W(1)) u_ext_sync (
        .clk   (CLK_80MHZ),
        .rst_n (RESET_N),
        .d     (bus.TRG_EXT),
        .q     (ext_sync)
    );

    // remember the previous synchronised external level for rising-edge detection
    always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
        if (!RESET_N) ext_prev <= 1'b0;
        else          ext_prev <= ext_sync;
    end

    assign ext_edge = ext_sync & ~ext_prev;
    assign req      = bus.TRG_SOFT | ext_edge;

`ifdef TRG_SEQ_PENDING_EN
    logic pending;

    // hold one request that arrived while busy; it is consumed on the first IDLE cycle
    always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
        if (!RESET_N)           pending <= 1'b0;
        else if (state == IDLE) pending <= 1'b0;
        else if (req)           pending <= 1'b1;
    end

    assign go = req | pending;
`else
    assign go = req;
`endif

    // quorum is capped at the number of enabled lanes; zero asks for all of them
    assign mask_pop = popcount(bus.TRG_MASK);
    assign req_now  = (bus.MIN_SCRODS_REQUIRED == 4'd0 || bus.MIN_SCRODS_REQUIRED > mask_pop)
                      ? mask_pop : bus.MIN_SCRODS_REQUIRED;

    // state and phase timer registers
    always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    // next state, phase timer and the start/done/timeout events
    always_comb begin
        state_n = state;
        timer_n = timer + 16'd1;
        start   = 1'b0;
        done    = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (go && bus.TRG_MASK != '0) begin
                    start   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (timer == ISSUE_LAST) begin
                    state_n = WAIT_ACK;
                    timer_n = '0;
                end
            end
            WAIT_ACK: begin
                if (popcount(ack_latched) >= req_eff) begin
                    done    = 1'b1;
                    state_n = DEAD;
                    timer_n = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    tmo     = 1'b1;
                    state_n = DEAD;
                    timer_n = '0;
                end
            end
            DEAD: begin
                if (timer >= DEAD_LAST) begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // trigger context, sticky masked ACKs and the one-cycle status pulses
    always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            mask_l      <= '0;
            req_eff     <= '0;
            ack_latched <= '0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            done_q <= done;
            tmo_q  <= tmo;
            if (start) begin
                mask_l      <= bus.TRG_MASK;
                req_eff     <= req_now;
                ack_latched <= '0;
            end else if (state == ISSUE || state == WAIT_ACK) begin
                ack_latched <= ack_latched | (ack_sync & mask_l);
            end
        end
    end

    // saturating issued and timeout counters
    always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            n_issued  <= '0;
            n_timeout <= '0;
        end else begin
            if (start && n_issued != '1) n_issued  <= n_issued + STAT_ONE;
            if (tmo && n_timeout != '1)  n_timeout <= n_timeout + STAT_ONE;
        end
    end

    assign bus.TRG            = (state == ISSUE) ? mask_l : '0;
    assign bus.BUSY           = state != IDLE;
    assign bus.TRG_DONE       = done_q;
    assign bus.TRG_TIMEOUT    = tmo_q;
    assign bus.ACK_LATCHED    = ack_latched;
    assign bus.TRG_STATISTICS = {n_timeout, n_issued};

endmodule
